mult_share_arbiter: RTL
=======================

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter NUM_BITS, default 32, operand width.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester operation request.
REQ-006 SHALL have port req_ready, output, NUM_REQ, per-requester accept; one-hot or zero.
REQ-007 SHALL have ports req_a and req_b, input, NUM_REQ x NUM_BITS, per-requester operands.
REQ-008 SHALL have port req_signed, input, NUM_REQ, per-requester signed-operation flag.
REQ-009 SHALL have port mul_start, output, 1, single-cycle start pulse to the shared multiplier.
REQ-010 SHALL have ports mul_a and mul_b, output, NUM_BITS, and mul_signed, output, 1; all registered operands.
REQ-011 SHALL have port mul_done, input, 1, multiplier completion pulse.
REQ-012 SHALL have port mul_result, input, 2*NUM_BITS, multiplier product, valid with mul_done.
REQ-013 SHALL have ports rsp_valid, output, 1, and rsp_ready, input, 1, response handshake.
REQ-014 SHALL have ports rsp_id, output, clog2(NUM_REQ), and rsp_result, output, 2*NUM_BITS.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-016 IDLE: when any req_valid is high, grant exactly one requester: assert its req_ready combinationally, capture its operands, flag and ID, then go to ISSUE.
REQ-017 ISSUE: assert mul_start for exactly one cycle with the captured operands, then go to WAIT.
REQ-018 WAIT: hold mul_a, mul_b and mul_signed stable; on mul_done, capture mul_result and go to RESP.
REQ-019 RESP: assert rsp_valid with rsp_id and rsp_result held stable until rsp_ready; on the handshake cycle, go to IDLE.
REQ-020 Minimum request-to-rsp_valid latency SHALL be 3 cycles plus the multiplier latency; back-to-back grants SHALL be one cycle after a response handshake.
REQ-021 req_ready SHALL be zero outside IDLE; requests arriving in other states wait and are not dropped.
REQ-022 mul_done received outside WAIT SHALL be ignored; mul_done in the ISSUE cycle SHALL be ignored.
REQ-023 mul_result SHALL be captured unmodified; the arbiter performs no sign processing.

Reset
REQ-024 rst SHALL force IDLE and drive req_ready, mul_start, rsp_valid, mul_a, mul_b, mul_signed, rsp_id and rsp_result to 0, with the round-robin pointer at 0.
REQ-025 rst asserted mid-operation (ISSUE/WAIT/RESP) SHALL abandon the transaction with no response; any mul_done that follows is ignored.

Configuration
REQ-026 With MULT_ARB_ROUND_ROBIN_EN defined, the grant SHALL be round-robin: search starts at the index after the last granted requester, wrapping at NUM_REQ-1 to 0.
REQ-027 Without MULT_ARB_ROUND_ROBIN_EN, the grant SHALL be fixed priority, with the lowest index winning.

Structure
REQ-028 A shared package mult_arb_pkg SHALL hold the FSM state enum, a request struct (a, b, signed, id) and the default parameter constants.
REQ-029 The grant logic SHALL be a sub-module rr_grant: request vector and pointer in, one-hot grant and encoded ID out.

Verification
REQ-030 Single request: requester 2 sends a=7, b=6, unsigned. Required: one mul_start pulse; rsp_id=2, rsp_result=42 after mul_done.
REQ-031 Signed request: requester 0 sends a=-3, b=5, req_signed=1. Required: mul_signed=1 during WAIT; response returns the multiplier value unchanged, -15.
REQ-032 Contention: all four requesters hold valid continuously. Required with RR: grant order 0,1,2,3,0. Required with fixed priority: grant order 0,0,0.
REQ-033 Backpressure: rsp_ready held low for 10 cycles. Required: rsp_valid, rsp_id and rsp_result stable; no new grant until the handshake.
REQ-034 Reset in WAIT: rst pulsed, then mul_done arrives. Required: no rsp_valid; FSM in IDLE; outputs at zero.
REQ-035 Spurious mul_done in IDLE. Required: no state change and no response.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared FSM state, captured-request struct and default sizes for mult_share_arbiter
// MAX_BITS / MAX_ID_W give the request struct room for any legal NUM_BITS (<= 64) and NUM_REQ (<= 8)
package mult_arb_pkg;
  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_NUM_BITS = 32;
  localparam int MAX_BITS     = 64;
  localparam int MAX_ID_W     = 3;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef struct packed {
    logic [MAX_BITS-1:0] a;
    logic [MAX_BITS-1:0] b;
    logic                sgn;
    logic [MAX_ID_W-1:0] id;
  } req_t;
endpackage

// File: rtl/mult_share_arbiter_rr_grant.sv
// rr_grant: rotating-priority one-hot grant, search starts at ptr and wraps
// Ports: req (request vector), ptr (first index searched), grant (one-hot or zero), id (encoded grant)
module rr_grant
  import mult_arb_pkg::*;
#(
  parameter int N = DEF_NUM_REQ,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] id
);
  // walk from farthest offset to nearest so the nearest requester to ptr wins
  always_comb begin
    grant = '0;
    id    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        grant                       = '0;
        grant[(int'(ptr) + k) % N]  = 1'b1;
        id                          = W'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one multiplier among NUM_REQ requesters (IDLE -> ISSUE -> WAIT -> RESP)
// Ports: clk, rst (sync, active high); req_valid/req_ready/req_a/req_b/req_signed per requester;
//        mul_start/mul_a/mul_b/mul_signed to the multiplier, mul_done/mul_result back;
//        rsp_valid/rsp_ready/rsp_id/rsp_result toward the requesters.
// Build option: MULT_ARB_ROUND_ROBIN_EN selects round-robin grant; otherwise lowest index wins.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int NUM_BITS = DEF_NUM_BITS,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0][NUM_BITS-1:0]   req_a,
  input  logic [NUM_REQ-1:0][NUM_BITS-1:0]   req_b,
  input  logic [NUM_REQ-1:0]                 req_signed,
  output logic                               mul_start,
  output logic [NUM_BITS-1:0]                mul_a,
  output logic [NUM_BITS-1:0]                mul_b,
  output logic                               mul_signed,
  input  logic                               mul_done,
  input  logic [2*NUM_BITS-1:0]              mul_result,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [IDW-1:0]                     rsp_id,
  output logic [2*NUM_BITS-1:0]              rsp_result
);
  state_t             state;
  req_t               cur;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     gnt_id;
  logic [NUM_REQ-1:0] grant;
  rr_grant #(.N(NUM_REQ)) u_grant (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .id    (gnt_id)
  );
  assign req_ready  = (state == IDLE && !rst) ? grant : '0;
  assign mul_a      = cur.a[NUM_BITS-1:0];
  assign mul_b      = cur.b[NUM_BITS-1:0];
  assign mul_signed = cur.sgn;
  assign rsp_id     = cur.id[IDW-1:0];
  // captured fields are zero-extended, so struct headroom above the live width stays clear
  a_headroom_clear: assert property (@(posedge clk)
    ((cur.a >> NUM_BITS) | (cur.b >> NUM_BITS)) == '0 && (cur.id >> IDW) == '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur        <= '0;
      ptr        <= '0;
      mul_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
    end else begin
      unique case (state)
        IDLE: if (|req_valid) begin
          cur       <= '{a: MAX_BITS'(req_a[gnt_id]), b: MAX_BITS'(req_b[gnt_id]),
                        sgn: req_signed[gnt_id], id: MAX_ID_W'(gnt_id)};
          mul_start <= 1'b1;
          state     <= ISSUE;
`ifdef MULT_ARB_ROUND_ROBIN_EN
          ptr       <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
`endif
        end
        ISSUE: begin
          mul_start <= 1'b0;
          state     <= WAIT;
        end
        WAIT: if (mul_done) begin
          rsp_result <= mul_result;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule
